// File: rtl/seq_1001_pkg.sv
// seq_1001_pkg: shared state encoding and sync defaults so transmitter and detector agree
package seq_1001_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, SYNC = 2'd1, DATA = 2'd2, DONE = 2'd3} state_e;
    localparam int DEF_SYNC_W = 4;
    localparam logic [DEF_SYNC_W-1:0] DEF_SYNC_PAT = 4'b1001;
endpackage

// File: rtl/seq_piso_shift.sv
// seq_piso_shift: parallel-load, shift-left register with zero fill, MSB presented serially
module seq_piso_shift #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              shift,
    input  logic [DATA_W-1:0] din,
    output logic              msb
);
    logic [DATA_W-1:0] q_q, q_d;
    // load has priority over shift; otherwise hold
    always_comb q_d = load ? din : shift ? {q_q[DATA_W-2:0], 1'b0} : q_q;
    // register with asynchronous clear
    always_ff @(posedge clk or posedge rst) q_q <= rst ? '0 : q_d;
    assign msb = q_q[DATA_W-1];
endmodule

// File: rtl/seq_1001_tx.sv
// seq_1001_tx: frames a parallel word as SYNC_PAT then payload MSB-first on a serial line
module seq_1001_tx
    import seq_1001_pkg::*;
#(
    parameter int                DATA_W   = 8,
    parameter int                SYNC_W   = DEF_SYNC_W,
    parameter logic [SYNC_W-1:0] SYNC_PAT = DEF_SYNC_PAT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    output logic              din_ready,
    output logic              dout,
    output logic              dout_valid,
    output logic              busy,
    output logic              frame_done
);
    localparam int CNT_W = $clog2(DATA_W > SYNC_W ? DATA_W : SYNC_W);
    localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(SYNC_W - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
    localparam logic [SYNC_W-1:0] SYNC_MSB = SYNC_W'(1) << (SYNC_W - 1);
    state_e state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic load, shift, msb;
    seq_piso_shift #(.DATA_W(DATA_W)) u_shift (
        .clk   (clk),
        .rst   (rst),
        .load  (load),
        .shift (shift),
        .din   (din),
        .msb   (msb)
    );
    // next state and counter; counter clears at each terminal count so it never wraps
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        shift   = 1'b0;
        case (state_q)
            IDLE: if (din_valid) begin
                state_d = SYNC;
                cnt_d   = '0;
                load    = 1'b1;
            end
            SYNC: begin
                state_d = cnt_q == SYNC_LAST ? DATA : SYNC;
                cnt_d   = cnt_q == SYNC_LAST ? '0 : cnt_q + 1'b1;
            end
            DATA: begin
                shift   = 1'b1;
                state_d = cnt_q == DATA_LAST ? DONE : DATA;
                cnt_d   = cnt_q == DATA_LAST ? '0 : cnt_q + 1'b1;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    // state and counter registers with asynchronous clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end
    // Moore outputs decoded from registered state only
    always_comb begin
        dout       = state_q == SYNC ? |(SYNC_PAT & (SYNC_MSB >> cnt_q)) : state_q == DATA ? msb : 1'b0;
        dout_valid = state_q == SYNC || state_q == DATA;
        busy       = state_q != IDLE;
        din_ready  = state_q == IDLE;
        frame_done = state_q == DONE;
    end
endmodule

// File: tb/tb_seq_1001_tx.sv
// tb_seq_1001_tx: scoreboard bench for the 8- and 16-bit transmitters against a frame-level model
module tb_seq_1001_tx;
    typedef struct {
        int          d;
        logic [31:0] bits;
        logic [31:0] payload;
        int          acc;
    } frame_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  din8 = '0;
    logic [15:0] din16 = '0;
    logic [1:0]  dvld = '0;
    logic [1:0]  rdy_w, dout_w, dv_w, busy_w, fd_w;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_acc[2] = '{-1000, -1000};
    frame_t exp_q[$];
    logic [31:0] cur_bits[2] = '{0, 0};
    int cur_n[2] = '{0, 0};
    int cur_start[2] = '{0, 0};

    seq_1001_tx #(.DATA_W(8)) dut8 (
        .clk(clk), .rst(rst), .din(din8), .din_valid(dvld[0]), .din_ready(rdy_w[0]),
        .dout(dout_w[0]), .dout_valid(dv_w[0]), .busy(busy_w[0]), .frame_done(fd_w[0])
    );
    seq_1001_tx #(.DATA_W(16)) dut16 (
        .clk(clk), .rst(rst), .din(din16), .din_valid(dvld[1]), .din_ready(rdy_w[1]),
        .dout(dout_w[1]), .dout_valid(dv_w[1]), .busy(busy_w[1]), .frame_done(fd_w[1])
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // monitor: per-cycle timing model plus frame assembly and scoreboard pop on frame_done
    int m_n, m_a, m_cnt, m_pos;
    logic e_dv, e_fd, e_rdy;
    frame_t m_f;
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            m_n = d != 0 ? 20 : 12;
            if (rst) last_acc[d] = -1000;
            m_a = last_acc[d];
            if (rst || cyc < m_a) begin
                e_dv = 1'b0; e_fd = 1'b0; e_rdy = 1'b1;
            end else begin
                e_dv = cyc <= m_a + m_n - 1;
                e_fd = cyc == m_a + m_n;
                e_rdy = cyc > m_a + m_n;
            end
            chk(dv_w[d] == e_dv, $sformatf("dout_valid[%0d] cyc=%0d", d, cyc), 32'(dv_w[d]), 32'(e_dv));
            chk(fd_w[d] == e_fd, $sformatf("frame_done[%0d] cyc=%0d", d, cyc), 32'(fd_w[d]), 32'(e_fd));
            chk(rdy_w[d] == e_rdy, $sformatf("din_ready[%0d] cyc=%0d", d, cyc), 32'(rdy_w[d]), 32'(e_rdy));
            chk(busy_w[d] == !e_rdy, $sformatf("busy[%0d] cyc=%0d", d, cyc), 32'(busy_w[d]), 32'(!e_rdy));
            if (!e_dv) chk(dout_w[d] == 1'b0, $sformatf("dout_idle[%0d] cyc=%0d", d, cyc), 32'(dout_w[d]), 0);
            if (rst) begin
                cur_n[d] = 0;
                cur_bits[d] = '0;
            end else begin
                if (dv_w[d]) begin
                    if (cur_n[d] == 0) cur_start[d] = cyc;
                    cur_bits[d] = {cur_bits[d][30:0], dout_w[d]};
                    cur_n[d]++;
                end
                if (fd_w[d]) begin
                    if (exp_q.size() == 0 || exp_q[0].d != d) begin
                        chk(1'b0, $sformatf("unexpected_frame[%0d]", d), cur_bits[d], 0);
                    end else begin
                        m_f = exp_q.pop_front();
                        chk(cur_n[d] == m_n, $sformatf("frame_len[%0d]", d), cur_n[d], m_n);
                        chk(cur_bits[d] == m_f.bits, $sformatf("frame_bits[%0d]", d), cur_bits[d], m_f.bits);
                        chk(cur_start[d] == m_f.acc, $sformatf("first_bit_cycle[%0d]", d), cur_start[d], m_f.acc);
                        if (m_f.payload == 0) begin
                            m_cnt = 0;
                            m_pos = -1;
                            for (int k = 3; k < cur_n[d]; k++)
                                if (((cur_bits[d] >> (cur_n[d] - 1 - k)) & 32'hF) == 32'h9) begin
                                    m_cnt++;
                                    m_pos = k;
                                end
                            chk(m_cnt == 1, "detector_count", m_cnt, 1);
                            chk(m_pos == 3, "detector_position", m_pos, 3);
                        end
                    end
                    cur_n[d] = 0;
                    cur_bits[d] = '0;
                end
            end
        end
        if (rst) exp_q.delete();
    end

    // driver: present a word and push its expected frame once the handshake completes
    task automatic send(input int d, input logic [31:0] data, output int acc);
        frame_t f;
        int w;
        logic [31:0] m;
        w = d != 0 ? 16 : 8;
        m = (32'h1 << w) - 1;
        if (d == 0) din8 = data[7:0]; else din16 = data[15:0];
        dvld[d] = 1'b1;
        acc = -1;
        for (int t = 0; t < 40 && acc < 0; t++) begin
            if (rdy_w[d]) begin
                acc = cyc + 1;
                f.d = d;
                f.payload = data & m;
                f.bits = (32'h9 << w) | (data & m);
                f.acc = acc;
                exp_q.push_back(f);
                last_acc[d] = acc;
                @(posedge clk);
            end else @(negedge clk);
        end
        if (acc < 0) chk(1'b0, "accept_timeout", 0, 1);
    endtask

    task automatic pulse(input int d, input logic [31:0] data);
        int a;
        send(d, data, a);
        @(negedge clk);
        dvld[d] = 1'b0;
    endtask

    task automatic drain();
        for (int t = 0; t < 100 && exp_q.size() != 0; t++) @(negedge clk);
        if (exp_q.size() != 0) chk(1'b0, "drain_timeout", exp_q.size(), 0);
        @(negedge clk);
    endtask

    int a1, a2;
    initial begin
        #1;
        chk(dout_w == 2'b00, "reset_dout", 32'(dout_w), 0);
        chk(dv_w == 2'b00, "reset_dout_valid", 32'(dv_w), 0);
        chk(busy_w == 2'b00, "reset_busy", 32'(busy_w), 0);
        chk(fd_w == 2'b00, "reset_frame_done", 32'(fd_w), 0);
        chk(rdy_w == 2'b11, "reset_din_ready", 32'(rdy_w), 3);
        #22 rst = 1'b0;
        repeat (5) @(negedge clk);
        pulse(0, 32'hA5);
        drain();
        send(0, 32'hFF, a1);
        @(negedge clk);
        send(0, 32'h00, a2);
        chk(a2 - a1 == 14, "accept_spacing", a2 - a1, 14);
        @(negedge clk);
        dvld[0] = 1'b0;
        drain();
        send(0, 32'h5A, a1);
        @(negedge clk);
        dvld[0] = 1'b0;
        while (cyc < a1 + 6) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk(dout_w[0] == 1'b0, "abort_dout", 32'(dout_w[0]), 0);
        chk(dv_w[0] == 1'b0, "abort_dout_valid", 32'(dv_w[0]), 0);
        chk(fd_w[0] == 1'b0, "abort_frame_done", 32'(fd_w[0]), 0);
        chk(rdy_w[0] == 1'b1, "abort_din_ready", 32'(rdy_w[0]), 1);
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        pulse(0, 32'h3C);
        drain();
        pulse(0, 32'h00);
        drain();
        for (int i = 0; i < 20; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            pulse(0, $urandom);
        end
        drain();
        pulse(1, 32'h8001);
        drain();
        for (int i = 0; i < 4; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            pulse(1, $urandom);
        end
        drain();
        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/seq_1001_tx.md
Name: seq_1001_tx

Overview:
- Serial frame transmitter; it is the generating end of the 1001-sync serial link.
- Accepts a parallel data word through a valid/ready handshake.
- Emits the 4-bit sync pattern 1001, then the data word MSB-first, on a single-bit line.
- Feeds the serial 1001 detector path; used as a bench stimulus source and as the on-chip link driver.

Parameters:
- DATA_W, 8, payload width in bits (legal 2..32).
- SYNC_W, 4, sync pattern width in bits.
- SYNC_PAT, 4'b1001, sync pattern, sent MSB-first.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset; asynchronous, active-high.
- din  in  DATA_W  payload word; sampled on accept.
- din_valid  in  1  payload request.
- din_ready  out  1  transmitter can accept; high only in IDLE.
- dout  out  1  serial line.
- dout_valid  out  1  high while a sync or data bit is on dout.
- busy  out  1  high in any state other than IDLE.
- frame_done  out  1  one-cycle pulse in DONE.

Behaviour:
- Reset (asynchronous, immediate, no clock edge needed):
  - state=IDLE, counter=0, shift register=0.
  - dout=0, dout_valid=0, busy=0, frame_done=0, din_ready=1.
- Moore FSM. Every output is a function of the registered state, counter and shift register only; no combinational path from din or din_valid to any output.
- IDLE:
  - din_ready=1, dout=0.
  - If din_valid=1 at the clock edge: capture din into the shift register, clear counter, go to SYNC. Otherwise stay in IDLE.
- SYNC:
  - dout=SYNC_PAT[SYNC_W-1-cnt], dout_valid=1. The counter increments each cycle.
  - When cnt=SYNC_W-1: clear counter, go to DATA.
- DATA:
  - dout=shift register MSB, dout_valid=1. Shift left each cycle with zero fill.
  - When cnt=DATA_W-1: go to DONE.
- DONE:
  - dout=0, dout_valid=0, frame_done=1. Next state is IDLE unconditionally.
- Latency:
  - First sync bit appears on dout in the cycle immediately after the accepting edge.
  - Frame occupies SYNC_W+DATA_W cycles of dout_valid, plus 1 DONE cycle.
  - Minimum accept-to-accept spacing is SYNC_W+DATA_W+2 cycles (IDLE must be visited).
- din_valid while not in IDLE: ignored; nothing is queued. The source must hold din_valid until it sees din_ready.
- din changing after accept: no effect on the frame in flight.
- Counter width: $clog2 of the larger of SYNC_W and DATA_W. It never wraps past its terminal value, because the state changes at the terminal count.
- Reset asserted mid-frame: the frame is aborted, the line drops to 0 immediately, and no frame_done is issued. After release, the first transmission is a fresh frame.
- Illegal state encoding: next state is IDLE.
- Payload bits may themselves contain 1001. Framing uniqueness is the receiver's responsibility; no bit-stuffing is done here.

Decomposition:
- Shared package seq_1001_pkg:
  - State encoding constants IDLE=0, SYNC=1, DATA=2, DONE=3 (2-bit).
  - SYNC_PAT and SYNC_W defaults, so transmitter and detector agree.
- One natural sub-module: seq_piso_shift, a DATA_W parallel-load, shift-left register with load and shift enables.
- FSM and counter remain in the top module.

Test Plan:
- Reset then idle 5 cycles -> dout=0, dout_valid=0, din_ready=1, busy=0 throughout.
- din=8'hA5, din_valid pulsed 1 cycle -> dout sequence 1,0,0,1 then 1,0,1,0,0,1,0,1 with dout_valid=1 for exactly 12 cycles. frame_done pulses on cycle 13 and din_ready returns on cycle 14.
- din_valid held high with din=8'hFF then 8'h00 -> two frames, accepts spaced exactly 14 cycles. Second payload is all zeros after 1001. din changes mid-frame do not corrupt the first frame.
- rst asserted asynchronously (between edges) during the 3rd data bit -> dout and dout_valid go to 0 before the next edge, and no frame_done. A new din=8'h3C after release transmits a complete, correct frame.
- Loopback into the 1001 detector with din=8'h00 -> the detector flags exactly once per frame, aligned to the last sync bit.
- DATA_W=16, din=16'h8001 -> 20 valid bits: 1001, then 1, fourteen 0s, 1. frame_done follows on cycle 21.
